theta_col_mixer: RTL and testbench
==================================

Name: theta_col_mixer

Overview:
- Downstream consumer of the mod-5 column index counter: `prev_idx`, `cur_idx` and `next_idx` come in; `idx_inc` and `idx_clr` go out.
- Loads five column parities C[0..4], then emits D[x] = C[x-1] ^ rotl(C[x+1], ROT) for x = 0..4, in order, using the externally supplied indices.
- Sits between the column-parity reducer (upstream) and the lane-update stage (downstream) of the permutation datapath.

Parameters:
- W, 64, lane/parity width in bits.
- ROT, 1, left-rotate amount applied to C[x+1]; legal range 0..W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new load/emit pass; sampled only in IDLE.
- in_valid  in  1  in_data holds the next parity word.
- in_ready  out  1  high only in LOAD.
- in_data  in  W  column parity, delivered in order C[0]..C[4].
- prev_idx  in  3  (cur-1) mod 5, from the index counter.
- cur_idx  in  3  current column, 0..4.
- next_idx  in  3  (cur+1) mod 5.
- idx_inc  out  1  advance the index counter; equals out_valid & out_ready.
- idx_clr  out  1  one-cycle pulse on start acceptance; resets the index counter to prev=4, cur=0, next=1.
- out_valid  out  1  D word valid.
- out_ready  in  1  downstream accepts the D word.
- out_data  out  W  D[cur_idx].
- out_idx  out  3  equals cur_idx.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the 5th D word is accepted.

Behaviour:
- Reset: state=IDLE, buf[0..4]=0, load_cnt=0, emit_cnt=0. All outputs low; out_data=0 while out_valid=0.
- States and transitions:
  - IDLE: start=1 -> LOAD, idx_clr=1 that same cycle, load_cnt=0.
  - LOAD: in_ready=1. On in_valid: buf[load_cnt] <= in_data, load_cnt++. The 5th accepted word (load_cnt==4) -> EMIT.
  - EMIT: out_valid=1. out_data is combinational from registered buf and the index inputs: buf[prev_idx] ^ rotl(buf[next_idx], ROT). On out_valid & out_ready: idx_inc=1, emit_cnt++. The 5th acceptance (emit_cnt==4) -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE. The counter has wrapped back to cur=0.
- Latency:
  - The first out_valid appears 1 cycle after the 5th load.
  - The counter updates on the same edge as the handshake, so the next column's D word is presented the following cycle.
  - No extra pipeline; full throughput is 1 word/cycle with out_ready held high.
- Backpressure: out_valid=0 is never asserted mid-pass. While out_ready=0, out_data and out_idx hold steady and idx_inc=0.
- Ignored or masked inputs:
  - start is ignored when busy.
  - in_valid is ignored outside LOAD.
  - idx_clr never coincides with idx_inc.
- Rotation: rotl is a modular left rotate of a W-bit word (bit W-1 wraps to bit 0). ROT=0 is a plain XOR.
- Illegal index: any index value > 4 drives out_data=0. Behaviour is otherwise unchanged; no error is flagged.
- rst mid-pass returns to the reset state immediately and discards partial data. The external counter is reset by the same rst.

Optional Feature:
- Macro: THETA_PARITY_CHK_EN.
- Defined:
  - Adds output err (1 bit) and an internal register xacc (W bits) that accumulates the XOR of all five loaded words.
  - At the DONE cycle, err=1 iff the XOR of all emitted D words != rotl(xacc, ROT) ^ xacc.
  - err clears on the next start or rst.
- Undefined: no err port, no xacc logic.

Decomposition:
- Package theta_pkg:
  - NUM_COLS=5, IDX_W=3.
  - State enum {IDLE, LOAD, EMIT, DONE}.
  - rotl function parameterised on W.
- One natural sub-module, col_buf5:
  - 5×W register file with a sync write port and two async read ports (prev, next).
  - Clears on rst.

Test Plan:
- W=8, ROT=1, out_ready=1: load 01,02,04,08,10 -> D = 14,09,12,24,0A with out_idx 0..4; done pulses 1 cycle after the last word; idx_inc asserted 5 cycles.
- Rotate wrap: load C1=80, all other C=00 -> D0=01, D2=80, all other D=00.
- out_ready toggling 1,0,0,1,…: out_data and out_idx stable while stalled; exactly 5 idx_inc pulses; D sequence unchanged from the first scenario.
- in_valid gaps during LOAD, plus start pulsed during EMIT -> loads complete correctly; the extra start is ignored; no idx_clr.
- rst asserted after 3 loads -> next cycle busy=0, in_ready=0, out_valid=0; a new pass then produces the correct D values.
- THETA_PARITY_CHK_EN defined, first scenario's data -> err=0 at DONE. Force a corrupted buf entry via a bench hook -> err=1.

Source files
------------

// File: rtl/theta_pkg.sv
// Shared types and helpers for the theta column mixer: column count, index width,
// controller states and a width-generic left rotate.
package theta_pkg;

  localparam int NUM_COLS = 5;
  localparam int IDX_W    = 3;
  localparam int MAX_W    = 256;  // widest lane the rotate helper supports

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } state_e;

  // Rotates the low w bits of v left by r; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int unsigned w,
                                            input int unsigned r);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) res[(i + r) % w] = v[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/col_buf5.sv
// Five-entry column parity buffer: one synchronous write port and two
// combinational read ports that return zero for out-of-range indices.
module col_buf5
  import theta_pkg::*;
#(
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_prev_idx,
  output logic [W-1:0]     rd_prev_data,
  input  logic [IDX_W-1:0] rd_next_idx,
  output logic [W-1:0]     rd_next_data
);

  logic [W-1:0] mem_q [NUM_COLS];
  logic [W-1:0] mem_d [NUM_COLS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_idx <= LAST_IDX)) mem_d[wr_idx] = wr_data;
  end

  // NOTE: the array is reset on purpose: a pass aborted by rst must not leak
  // stale parities into the next one. This keeps it in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_prev_data = (rd_prev_idx <= LAST_IDX) ? mem_q[rd_prev_idx] : '0;
  assign rd_next_data = (rd_next_idx <= LAST_IDX) ? mem_q[rd_next_idx] : '0;

endmodule

// File: rtl/theta_col_mixer.sv
// Theta column mixer: loads C[0..4], then emits D[x] = C[x-1] ^ rotl(C[x+1], ROT)
// driven by an external mod-5 index counter. THETA_PARITY_CHK_EN adds the err check.
module theta_col_mixer
  import theta_pkg::*;
#(
  parameter int W   = 64,
  parameter int ROT = 1
) (
`ifdef THETA_PARITY_CHK_EN
  output logic             err,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [IDX_W-1:0] prev_idx,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [IDX_W-1:0] next_idx,
  output logic             idx_inc,
  output logic             idx_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] emit_cnt_q, emit_cnt_d;
  logic             wr_en;
  logic [W-1:0]     rd_prev, rd_next, mix;
  logic             idx_ok;

  col_buf5 #(.W(W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (load_cnt_q),
    .wr_data     (in_data),
    .rd_prev_idx (prev_idx),
    .rd_prev_data(rd_prev),
    .rd_next_idx (next_idx),
    .rd_next_data(rd_next)
  );

  assign idx_ok = (prev_idx <= LAST_IDX) && (cur_idx <= LAST_IDX) && (next_idx <= LAST_IDX);
  assign mix    = rd_prev ^ W'(rotl(MAX_W'(rd_next), W, ROT));

  // NOTE: every output is given a default before the case so no path leaves a
  // signal unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    emit_cnt_d = emit_cnt_q;
    wr_en      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_clr    = 1'b1;
          load_cnt_d = '0;
          emit_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en      = 1'b1;
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_IDX) state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          idx_inc    = 1'b1;
          emit_cnt_d = emit_cnt_q + 1'b1;
          if (emit_cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = (out_valid && idx_ok) ? mix : '0;
  assign out_idx  = cur_idx;
  assign busy     = (state_q != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      emit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

`ifdef THETA_PARITY_CHK_EN
  // XOR of all D words must equal X ^ rotl(X) where X is the XOR of all C words.
  logic [W-1:0] xacc_q, xacc_d;
  logic [W-1:0] dacc_q, dacc_d;
  logic         err_q, err_d;
  logic [W-1:0] dacc_final;

  assign dacc_final = dacc_q ^ out_data;

  always_comb begin
    xacc_d = xacc_q;
    dacc_d = dacc_q;
    err_d  = err_q;
    if (state_q == IDLE && start) begin
      xacc_d = '0;
      dacc_d = '0;
      err_d  = 1'b0;
    end
    if (wr_en) xacc_d = xacc_q ^ in_data;
    if (idx_inc) begin
      dacc_d = dacc_final;
      if (emit_cnt_q == LAST_IDX)
        err_d = (dacc_final != (xacc_q ^ W'(rotl(MAX_W'(xacc_q), W, ROT))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xacc_q <= '0;
      dacc_q <= '0;
      err_q  <= 1'b0;
    end else begin
      xacc_q <= xacc_d;
      dacc_q <= dacc_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_theta_col_mixer.sv
// Scoreboard bench for theta_col_mixer (W=8, ROT=1) with a behavioural mod-5
// index counter; build with THETA_PARITY_CHK_EN to also exercise err.
module tb_theta_col_mixer;

  localparam int W   = 8;
  localparam int ROT = 1;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, idx_inc, idx_clr, out_valid, busy, done;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic [2:0]   prev_idx, cur_idx, next_idx;
`ifdef THETA_PARITY_CHK_EN
  logic         err;
`endif

  logic [2:0] cnt = 3'd0;
  logic [2:0] corrupt_col = 3'd7;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   inc_cnt = 0;
  int   clr_cnt = 0;
  logic hs_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] held_data = '0;
  logic [2:0]   held_idx = '0;

  always #5 clk = ~clk;

  theta_col_mixer #(.W(W), .ROT(ROT)) dut (
`ifdef THETA_PARITY_CHK_EN
    .err      (err),
`endif
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .prev_idx (prev_idx),
    .cur_idx  (cur_idx),
    .next_idx (next_idx),
    .idx_inc  (idx_inc),
    .idx_clr  (idx_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  // External mod-5 index counter; corrupt_col forces an illegal prev index.
  always @(posedge clk) begin
    if (rst || idx_clr) cnt <= 3'd0;
    else if (idx_inc)   cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
  end
  assign cur_idx  = cnt;
  assign next_idx = (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
  assign prev_idx = (cnt == corrupt_col) ? 3'd7 : ((cnt == 3'd0) ? 3'd4 : cnt - 3'd1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] model_rotl(input logic [W-1:0] v);
    return (v << ROT) | (v >> (W - ROT));
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) check("idx_inc_eq_hs", idx_inc, out_ready);
      else           check("idle_data_zero", out_data, 0);
      if (stall_prev && out_valid) begin
        check("stall_data", out_data, held_data);
        check("stall_idx", out_idx, held_idx);
      end
      if (out_valid && out_ready) begin
        inc_cnt++;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("d_word", out_data, e.d);
          check("d_idx", out_idx, e.idx);
        end
      end
      if (idx_clr) begin
        clr_cnt++;
        check("clr_inc_excl", idx_inc, 0);
      end
      if (done) check("done_latency", hs_prev, 1);
      hs_prev    = out_valid && out_ready;
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_idx   = out_idx;
    end else begin
      hs_prev    = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full load/emit pass with scoreboard push, optional load gaps,
  // toggling out_ready and a spurious mid-EMIT start.
  task automatic do_pass(input logic [W-1:0] c [5], input bit toggle_ready,
                         input bit gaps, input bit start_mid);
    int  i;
    bit  gap_now;
    bit  seen_done;
    for (int x = 0; x < 5; x++) begin
      exp_t e;
      e.d   = c[(x + 4) % 5] ^ model_rotl(c[(x + 1) % 5]);
      if (x == int'(corrupt_col)) e.d = '0;
      e.idx = 3'(x);
      sb.push_back(e);
    end
    inc_cnt = 0;
    clr_cnt = 0;
    pulse_start();
    i = 0;
    gap_now = 1'b0;
    while (i < 5) begin
      if (gaps && gap_now) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = c[i];
        i++;
      end
      gap_now = ~gap_now;
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
`ifdef THETA_PARITY_CHK_EN
      check("err_cleared", err, 0);
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 64 && !seen_done; cyc++) begin
      out_ready = toggle_ready ? (cyc % 3 == 0) : 1'b1;
      start     = start_mid && (cyc == 1);
      @(negedge clk);
      if (cyc == 0) check("first_valid", out_valid, 1);
      if (done) begin
        seen_done = 1'b1;
`ifdef THETA_PARITY_CHK_EN
        check("err_at_done", err, (corrupt_col <= 3'd4));
`endif
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("done_seen", seen_done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("inc_count", inc_cnt, 5);
    check("clr_count", clr_cnt, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] base [5];
    logic [W-1:0] wrap [5];
    logic [W-1:0] mixd [5];
    base = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    wrap = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
    mixd = '{8'h3C, 8'hA5, 8'hF0, 8'h0F, 8'h81};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_idx_clr", idx_clr, 0);
    #1 rst = 1'b0;

    // in_valid before start must be ignored.
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    do_pass(base, 1'b0, 1'b0, 1'b0);
    do_pass(wrap, 1'b0, 1'b0, 1'b0);
    do_pass(base, 1'b1, 1'b0, 1'b0);
    do_pass(mixd, 1'b0, 1'b1, 1'b1);

    // Abort a pass after three loads.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = mixd[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    do_pass(base, 1'b0, 1'b0, 1'b0);

    // Illegal prev index on column 2 zeroes that word only.
    corrupt_col = 3'd2;
    do_pass(base, 1'b0, 1'b0, 1'b0);
    corrupt_col = 3'd7;
    do_pass(wrap, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
